snn_lif1d: RTL and testbench

SNN_LIF1D -- requirements
Module: snn_lif1d

---
 rtl/snn_pkg.sv | 36 +++
 rtl/snn_lif_neuron_update.sv | 48 ++++
 rtl/snn_lif1d.sv | 277 +++++++++++++++++++++++++++
 tb/tb_snn_lif1d.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared definitions for the 1-D leaky integrate-and-fire spiking layer.
//
// Contents:
//   - bit offsets/widths of the fields packed into the 32-bit stream words
//     (position, channel, value) and into the configuration word
//   - the layer FSM state encoding
//   - the threshold loaded at reset
//
// Optional build macro used by the layer: SNN_LIF_REFRACTORY_EN
package snn_pkg;

    // Input/output stream word: {position[31:16], channel[15:8], value[7:0]}
    localparam int POS_LSB = 16;
    localparam int POS_W   = 16;
    localparam int CH_LSB  = 8;
    localparam int CH_W    = 8;
    localparam int VAL_LSB = 0;
    localparam int VAL_W   = 8;

    // Configuration word: {unused[31:20], leak_shift[19:16], threshold[15:0]}
    localparam int THR_LSB  = 0;
    localparam int THR_W    = 16;
    localparam int LEAK_LSB = 16;
    localparam int LEAK_W   = 4;

    localparam logic [THR_W-1:0] DEFAULT_THRESHOLD = 16'd200;

    typedef enum logic [2:0] {
        ST_ACCUM = 3'd0,   // integrate incoming pooled values
        ST_SWEEP = 3'd1,   // leak/compare one neuron per cycle
        ST_EMIT  = 3'd2,   // drain the hold register mid-sweep (tlast = 0)
        ST_FLUSH = 3'd3,   // drain the final held spike (tlast = 1)
        ST_DONE  = 3'd4    // one-cycle layer_done pulse
    } state_t;

endpackage

// File: rtl/snn_lif_neuron_update.sv
// Combinational membrane update for a single neuron. The layer time-multiplexes
// one instance of this block across all neurons during its sweep.
//
// Ports:
//   v           in   current membrane potential
//   threshold   in   firing threshold (zero-extended for the compare)
//   leak_shift  in   leak amount: v' = v - (v >> leak_shift); 0 disables leak
//   refractory  in   neuron fired last sweep: it may not fire, vmem is cleared
//   v_next      out  membrane potential to write back
//   fire        out  neuron emits a spike this sweep
module snn_lif_neuron_update #(
    parameter int VMEM_WIDTH = 16
) (
    input  logic [VMEM_WIDTH-1:0] v,
    input  logic [15:0]           threshold,
    input  logic [3:0]            leak_shift,
    input  logic                  refractory,
    output logic [VMEM_WIDTH-1:0] v_next,
    output logic                  fire
);

    // Compare at the wider of the two operand widths so neither side truncates.
    localparam int CW = (VMEM_WIDTH > 16) ? VMEM_WIDTH : 16;

    logic [VMEM_WIDTH-1:0] v_leak;
    logic [CW-1:0]         v_cmp;
    logic [CW-1:0]         thr_cmp;

    always_comb begin
        v_leak = v;
        // Shift of zero would subtract v from itself; zero means "no leak".
        if (leak_shift != 4'd0) begin
            v_leak = v - (v >> leak_shift);
        end
        v_cmp   = CW'(v_leak);
        thr_cmp = CW'(threshold);

        fire   = 1'b0;
        v_next = v_leak;
        if (refractory) begin
            v_next = '0;
        end else if (v_cmp >= thr_cmp) begin
            fire   = 1'b1;
            v_next = '0;
        end
    end

endmodule

// File: rtl/snn_lif1d.sv
// 1-D leaky integrate-and-fire spiking layer.
//
// Pooled values arrive as {position, channel, value} beats and are integrated
// into per-neuron membrane potentials. A beat with tlast ends the timestep:
// the layer then sweeps all neurons in ascending index order, applies leak,
// fires neurons at or above threshold and streams spikes out as
// {position, channel, 8'd1}; the final spike of a timestep carries tlast.
//
// Build option: define SNN_LIF_REFRACTORY_EN to give every neuron a
// refractory bit (a neuron that fired cannot fire on the following sweep).
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   enable                      low: no input accepted, FSM frozen
//   s_axis_input_*              pooled-value input stream (tlast = end of timestep)
//   m_axis_output_*             spike output stream
//   config_valid, config_data   threshold[15:0], leak_shift[19:16]; ACCUM only
//   busy                        high during SWEEP, EMIT and FLUSH
//   layer_done                  one-cycle pulse after each timestep's sweep
//
// Handshake: both streams use valid/ready; a beat transfers on a rising edge
// where valid && ready. The output beat (valid, data, last) is held stable
// until it transfers; while enable is low the output valid is masked so that
// nothing transfers while the FSM is frozen.
module snn_lif1d
    import snn_pkg::*;
#(
    parameter int INPUT_LENGTH   = 8,
    parameter int INPUT_CHANNELS = 4,
    parameter int VMEM_WIDTH     = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        s_axis_input_tvalid,
    output logic        s_axis_input_tready,
    input  logic        s_axis_input_tlast,
    input  logic [31:0] s_axis_input_tdata,
    output logic        m_axis_output_tvalid,
    input  logic        m_axis_output_tready,
    output logic        m_axis_output_tlast,
    output logic [31:0] m_axis_output_tdata,
    input  logic        config_valid,
    input  logic [31:0] config_data,
    output logic        busy,
    output logic        layer_done
);

    localparam int NUM_NEURONS = INPUT_LENGTH * INPUT_CHANNELS;
    localparam int IDX_W       = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    state_t state;
    state_t state_next;

    logic [VMEM_WIDTH-1:0] vmem [NUM_NEURONS];
    logic [THR_W-1:0]      threshold;
    logic [LEAK_W-1:0]     leak_shift;

    // Sweep position: flat index plus the matching (position, channel) pair,
    // kept as counters so no divider is needed to label spikes.
    logic [IDX_W-1:0] idx;
    logic [POS_W-1:0] sw_pos;
    logic [CH_W-1:0]  sw_ch;

    // One-entry spike hold register plus the spike waiting behind it in EMIT.
    logic             hold_valid;
    logic [POS_W-1:0] hold_pos;
    logic [CH_W-1:0]  hold_ch;
    logic [POS_W-1:0] pend_pos;
    logic [CH_W-1:0]  pend_ch;
    logic             sweep_last;  // EMIT was entered from the final neuron

`ifdef SNN_LIF_REFRACTORY_EN
    logic [NUM_NEURONS-1:0] refr;
`endif

    // ---------------- input decode and saturating accumulate ----------------
    logic [POS_W-1:0]    in_pos;
    logic [CH_W-1:0]     in_ch;
    logic [VAL_W-1:0]    in_val;
    logic                in_in_range;
    logic [31:0]         in_idx_wide;
    logic [IDX_W-1:0]    in_idx;
    logic                in_accept;
    logic [VMEM_WIDTH:0] acc_sum;
    logic [VMEM_WIDTH-1:0] acc_sat;

    always_comb begin
        in_pos      = s_axis_input_tdata[POS_LSB +: POS_W];
        in_ch       = s_axis_input_tdata[CH_LSB +: CH_W];
        in_val      = s_axis_input_tdata[VAL_LSB +: VAL_W];
        in_in_range = (32'(in_pos) < 32'(INPUT_LENGTH)) &&
                      (32'(in_ch) < 32'(INPUT_CHANNELS));
        in_idx_wide = 32'(in_pos) * 32'(INPUT_CHANNELS) + 32'(in_ch);
        in_idx      = in_idx_wide[IDX_W-1:0];
        in_accept   = (state == ST_ACCUM) && enable && s_axis_input_tvalid;
        acc_sum     = {1'b0, vmem[in_idx]} + (VMEM_WIDTH+1)'(in_val);
        acc_sat     = acc_sum[VMEM_WIDTH] ? '1 : acc_sum[VMEM_WIDTH-1:0];
    end

    logic unused_bits;
    assign unused_bits = ^{in_idx_wide[31:IDX_W], config_data[31:LEAK_LSB+LEAK_W]};

    // ---------------- shared neuron update ----------------
    logic [VMEM_WIDTH-1:0] upd_v;
    logic                  upd_fire;
    logic                  upd_refr;

`ifdef SNN_LIF_REFRACTORY_EN
    assign upd_refr = refr[idx];
`else
    assign upd_refr = 1'b0;
`endif

    snn_lif_neuron_update #(
        .VMEM_WIDTH (VMEM_WIDTH)
    ) u_update (
        .v          (vmem[idx]),
        .threshold  (threshold),
        .leak_shift (leak_shift),
        .refractory (upd_refr),
        .v_next     (upd_v),
        .fire       (upd_fire)
    );

    // ---------------- FSM ----------------
    logic out_show;
    logic out_hs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_ACCUM;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next           = state;
        s_axis_input_tready  = 1'b0;
        m_axis_output_tvalid = 1'b0;
        m_axis_output_tlast  = 1'b0;
        m_axis_output_tdata  = '0;
        busy                 = 1'b0;
        layer_done           = 1'b0;
        out_show             = 1'b0;

        case (state)
            ST_ACCUM: begin
                s_axis_input_tready = enable;
                if (in_accept && s_axis_input_tlast) begin
                    state_next = ST_SWEEP;
                end
            end
            ST_SWEEP: begin
                busy = 1'b1;
                if (enable) begin
                    if (upd_fire && hold_valid) begin
                        state_next = ST_EMIT;
                    end else if (idx == LAST_IDX) begin
                        state_next = ST_FLUSH;
                    end
                end
            end
            ST_EMIT: begin
                busy     = 1'b1;
                out_show = 1'b1;
                if (enable && m_axis_output_tready) begin
                    state_next = sweep_last ? ST_FLUSH : ST_SWEEP;
                end
            end
            ST_FLUSH: begin
                // Always visited so a timestep costs the same minimum latency
                // whether or not anything fired.
                busy                = 1'b1;
                out_show            = hold_valid;
                m_axis_output_tlast = hold_valid;
                if (enable && (!hold_valid || m_axis_output_tready)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                layer_done = enable;
                if (enable) begin
                    state_next = ST_ACCUM;
                end
            end
            default: state_next = ST_ACCUM;
        endcase

        m_axis_output_tvalid = out_show && enable;
        if (out_show) begin
            m_axis_output_tdata = {hold_pos, hold_ch, 8'd1};
        end
    end

    assign out_hs = m_axis_output_tvalid && m_axis_output_tready;

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            threshold  <= DEFAULT_THRESHOLD;
            leak_shift <= '0;
            idx        <= '0;
            sw_pos     <= '0;
            sw_ch      <= '0;
            hold_valid <= 1'b0;
            hold_pos   <= '0;
            hold_ch    <= '0;
            pend_pos   <= '0;
            pend_ch    <= '0;
            sweep_last <= 1'b0;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                vmem[i] <= '0;
            end
`ifdef SNN_LIF_REFRACTORY_EN
            refr <= '0;
`endif
        end else if (enable) begin
            case (state)
                ST_ACCUM: begin
                    if (config_valid) begin
                        threshold  <= config_data[THR_LSB +: THR_W];
                        leak_shift <= config_data[LEAK_LSB +: LEAK_W];
                    end
                    // Out-of-range beats are consumed but leave vmem untouched.
                    if (in_accept && in_in_range) begin
                        vmem[in_idx] <= acc_sat;
                    end
                    if (in_accept && s_axis_input_tlast) begin
                        idx    <= '0;
                        sw_pos <= '0;
                        sw_ch  <= '0;
                    end
                end
                ST_SWEEP: begin
                    vmem[idx] <= upd_v;
`ifdef SNN_LIF_REFRACTORY_EN
                    refr[idx] <= upd_fire;
`endif
                    idx <= idx + IDX_W'(1);
                    if (sw_ch == CH_W'(INPUT_CHANNELS - 1)) begin
                        sw_ch  <= '0;
                        sw_pos <= sw_pos + 16'd1;
                    end else begin
                        sw_ch <= sw_ch + 8'd1;
                    end
                    if (upd_fire) begin
                        if (hold_valid) begin
                            pend_pos   <= sw_pos;
                            pend_ch    <= sw_ch;
                            sweep_last <= (idx == LAST_IDX);
                        end else begin
                            hold_valid <= 1'b1;
                            hold_pos   <= sw_pos;
                            hold_ch    <= sw_ch;
                        end
                    end
                end
                ST_EMIT: begin
                    if (out_hs) begin
                        hold_pos <= pend_pos;
                        hold_ch  <= pend_ch;
                    end
                end
                ST_FLUSH: begin
                    if (out_hs) begin
                        hold_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_snn_lif1d.sv
// Self-checking bench for snn_lif1d (default parameters: 8 positions x 4
// channels, 16-bit membranes). A reference model of the membranes predicts
// the spikes of each timestep when its tlast beat is sent; predictions are
// queued and compared against the output stream as beats transfer.
// Honours SNN_LIF_REFRACTORY_EN in the reference model.
module tb_snn_lif1d;

    localparam int L = 8;
    localparam int C = 4;
    localparam int N = L * C;
`ifdef SNN_LIF_REFRACTORY_EN
    localparam bit REFR_EN = 1'b1;
`else
    localparam bit REFR_EN = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b1;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic        s_tlast = 1'b0;
    logic [31:0] s_tdata = '0;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic        m_tlast;
    logic [31:0] m_tdata;
    logic        config_valid = 1'b0;
    logic [31:0] config_data = '0;
    logic        busy;
    logic        layer_done;

    always #5 clk = ~clk;

    snn_lif1d dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .enable               (enable),
        .s_axis_input_tvalid  (s_tvalid),
        .s_axis_input_tready  (s_tready),
        .s_axis_input_tlast   (s_tlast),
        .s_axis_input_tdata   (s_tdata),
        .m_axis_output_tvalid (m_tvalid),
        .m_axis_output_tready (m_tready),
        .m_axis_output_tlast  (m_tlast),
        .m_axis_output_tdata  (m_tdata),
        .config_valid         (config_valid),
        .config_data          (config_data),
        .busy                 (busy),
        .layer_done           (layer_done)
    );

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int tlast_cyc = 0;
    int ready_mode = 1;        // 0: stall, 1: always ready, 2: random
    logic [32:0] exp_q[$];     // {tdata, tlast}

    int mdl_v[N];
    bit mdl_refr[N];
    int mdl_thr = 200;
    int mdl_leak = 0;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       m_tready = 1'b0;
            1:       m_tready = 1'b1;
            default: m_tready = ($urandom_range(0, 9) < 7);
        endcase
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mdl_v[i] = 0;
            mdl_refr[i] = 1'b0;
        end
        mdl_thr = 200;
        mdl_leak = 0;
    endtask

    task automatic model_sweep();
        int fired[$];
        for (int i = 0; i < N; i++) begin
            int v;
            v = mdl_v[i];
            if (REFR_EN && mdl_refr[i]) begin
                mdl_v[i] = 0;
                mdl_refr[i] = 1'b0;
            end else begin
                if (mdl_leak != 0) v = v - (v >> mdl_leak);
                if (v >= mdl_thr) begin
                    fired.push_back(i);
                    mdl_v[i] = 0;
                    mdl_refr[i] = 1'b1;
                end else begin
                    mdl_v[i] = v;
                end
            end
        end
        for (int k = 0; k < fired.size(); k++) begin
            exp_q.push_back({16'(fired[k] / C), 8'(fired[k] % C), 8'd1, (k == fired.size() - 1)});
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    bit          prev_stall = 1'b0;
    bit          prev_done = 1'b0;
    logic [32:0] prev_beat = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                assert (m_tvalid === 1'b1 && {m_tdata, m_tlast} === prev_beat) else begin
                    errors++;
                    $error("FAIL stall_stable: got v=%0b %h expected v=1 %h", m_tvalid, {m_tdata, m_tlast}, prev_beat);
                end
            end
            if (m_tvalid && m_tready) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_beat: got %h expected no beat", {m_tdata, m_tlast});
                end
                if (exp_q.size() != 0) begin
                    logic [32:0] e;
                    e = exp_q.pop_front();
                    checks++;
                    assert ({m_tdata, m_tlast} === e) else begin
                        errors++;
                        $error("FAIL out_beat: got %h expected %h", {m_tdata, m_tlast}, e);
                    end
                end
            end
            prev_stall = m_tvalid && !m_tready;
            prev_beat = {m_tdata, m_tlast};
            if (layer_done) begin
                checks++;
                assert (!prev_done) else begin
                    errors++;
                    $error("FAIL done_pulse_width: got 2+ cycles expected 1");
                end
            end
            prev_done = layer_done;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_beat(input int p, input int c, input int v, input bit last);
        int n;
        n = 0;
        @(negedge clk);
        s_tvalid = 1'b1;
        s_tdata = {16'(p), 8'(c), 8'(v)};
        s_tlast = last;
        while (!s_tready && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("input_ready", s_tready, 1);
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
        if (p < L && c < C) begin
            mdl_v[p * C + c] = mdl_v[p * C + c] + v;
            if (mdl_v[p * C + c] > 65535) mdl_v[p * C + c] = 65535;
        end
        if (last) begin
            tlast_cyc = cyc;
            model_sweep();
        end
    endtask

    task automatic wait_done(input string tag);
        int n;
        int lat;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!layer_done && n < 1000);
        check({tag, "_layer_done"}, layer_done, 1);
        lat = cyc - tlast_cyc + 1;
        check({tag, "_min_latency"}, (lat >= N + 2), 1);
        check({tag, "_all_beats_out"}, exp_q.size(), 0);
    endtask

    task automatic cfg_apply(input int thr, input int leak);
        @(negedge clk);
        config_valid = 1'b1;
        config_data = {12'd0, 4'(leak), 16'(thr)};
        @(posedge clk);
        #1;
        config_valid = 1'b0;
        mdl_thr = thr;
        mdl_leak = leak;
    endtask

    // Issued during a sweep; must have no effect.
    task automatic cfg_while_busy(input int thr);
        @(negedge clk);
        check("busy_in_sweep", busy, 1);
        config_valid = 1'b1;
        config_data = {12'd0, 4'd0, 16'(thr)};
        @(posedge clk);
        #1;
        config_valid = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_m_tvalid"}, m_tvalid, 0);
        check({tag, "_m_tlast"}, m_tlast, 0);
        check({tag, "_m_tdata"}, m_tdata, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_layer_done"}, layer_done, 0);
        check({tag, "_s_tready"}, s_tready, 1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        model_reset();

        // Reset state
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;

        // Test 1: 100 + 100 reaches threshold 200 exactly; a config attempt
        // during the sweep (threshold 5) must be ignored.
        send_beat(0, 0, 100, 0);
        send_beat(0, 0, 100, 1);
        cfg_while_busy(5);
        wait_done("t1");

        // Test 2: 150 stays below, +60 fires pos3 ch1.
        send_beat(3, 1, 150, 1);
        wait_done("t2a");
        send_beat(3, 1, 60, 1);
        wait_done("t2b");

        // Test 3: leak_shift 1: 255 -> 128, then 228 -> 114; then no leak:
        // 114+85 = 199 stays, +1 = 200 fires.
        cfg_apply(200, 1);
        send_beat(2, 2, 255, 1);
        wait_done("t3a");
        send_beat(2, 2, 100, 1);
        wait_done("t3b");
        cfg_apply(200, 0);
        send_beat(2, 2, 85, 1);
        wait_done("t3c");
        send_beat(2, 2, 1, 1);
        wait_done("t3d");

        // Test 4: two spikes under 20+ cycles of backpressure.
        ready_mode = 0;
        send_beat(1, 0, 250, 0);
        send_beat(5, 3, 250, 1);
        n = 0;
        while (!m_tvalid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("t4_valid_seen", m_tvalid, 1);
        repeat (20) begin
            @(negedge clk);
            check("t4_stall_valid", m_tvalid, 1);
        end
        ready_mode = 1;
        wait_done("t4");

        // Random timesteps with random config and random backpressure.
        ready_mode = 2;
        for (int t = 0; t < 4; t++) begin
            int nb;
            cfg_apply($urandom_range(150, 350), $urandom_range(0, 2));
            nb = $urandom_range(4, 10);
            for (int b = 0; b < nb; b++) begin
                send_beat($urandom_range(0, 8), $urandom_range(0, 4), $urandom_range(0, 255), (b == nb - 1));
            end
            wait_done("rand");
        end
        ready_mode = 1;

        // Test 5: out-of-range beat is dropped but its tlast ends the timestep.
        send_beat(9, 0, 255, 1);
        wait_done("t5a");
        // Reset in the middle of a sweep.
        send_beat(7, 3, 250, 1);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midsweep_reset");
        exp_q.delete();
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        check("post_reset_busy", busy, 0);
        check("post_reset_tvalid", m_tvalid, 0);
        // Defaults restored: threshold 200 fires on exactly 200; the
        // interrupted neuron 31 must not fire.
        send_beat(0, 2, 200, 1);
        wait_done("t5b");

        // Test 6: fire, then two further timesteps of 250 into neuron 0.
        send_beat(0, 0, 250, 1);
        wait_done("t6a");
        send_beat(0, 0, 250, 1);
        wait_done("t6b");
        send_beat(0, 0, 250, 1);
        wait_done("t6c");

        repeat (5) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
